// File: rtl/hamm_enco_stream.sv
// hamm_enco_stream: streaming Hamming encoder with an optional overall-parity (SECDED) bit,
// single-bit fault injection and a 2-entry output FIFO.
//
// Ports
//   clk, rst_n          single clock, asynchronous active-low reset
//   msg[1:K]            data word, msg[1] is the first data bit
//   msg_valid/msg_ready input handshake; a word is accepted when both are high at an edge
//   inj_en, inj_pos     flip codeword position inj_pos (1-based) of the word being accepted
//   encoded_msg[1:N]    codeword at the FIFO head (all zeros when empty)
//   enc_valid/enc_ready output handshake
//   word_cnt            number of accepted words, wraps at 2^CW
module hamm_enco_stream #(
    parameter int K      = 16,
    parameter int P      = 5,
    parameter int SECDED = 0,
    parameter int CW     = 16
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [1:K]                           msg,
    input  logic                                 msg_valid,
    output logic                                 msg_ready,
    input  logic                                 inj_en,
    input  logic [$clog2(K+P+SECDED+1)-1:0]      inj_pos,
    output logic [1:K+P+SECDED]                  encoded_msg,
    output logic                                 enc_valid,
    input  logic                                 enc_ready,
    output logic [CW-1:0]                        word_cnt
);

    localparam int N = K + P + SECDED;
    localparam int M = K + P;

    if (2 ** P < K + P + 1) begin : g_bad_p
        $fatal(1, "hamm_enco_stream: P too small for K (need 2^P >= K+P+1)");
    end

    // Codeword indexed by 1-based position.
    logic [N:1] code;

    always_comb begin
        int  d;
        logic par;
        code = '0;
        d    = 1;
        par  = 1'b0;
        // Data bits fill the non-power-of-two positions in ascending order.
        for (int pos = 1; pos <= M; pos++) begin
            if ((pos & (pos - 1)) != 0 && d <= K) begin
                code[pos] = msg[d];
                d++;
            end
        end
        for (int i = 0; i < P; i++) begin
            par = 1'b0;
            for (int pos = 1; pos <= M; pos++) begin
                if (((pos >> i) & 1) == 1 && (pos & (pos - 1)) != 0) begin
                    par = par ^ code[pos];
                end
            end
            if ((1 << i) <= M) begin
                code[1 << i] = par;
            end
        end
        if (SECDED != 0) begin
            code[N] = ^code[M:1];
        end
        // Injection comes last so the parity bits describe the unflipped word.
        if (inj_en && inj_pos != '0 && int'(inj_pos) <= N) begin
            code[int'(inj_pos)] = ~code[int'(inj_pos)];
        end
    end

    // 2-entry FIFO
    logic [N:1]    mem_q [2];
    logic          rd_ptr_q;
    logic          wr_ptr_q;
    logic [1:0]    cnt_q;
    logic [1:0]    cnt_d;
    logic [CW-1:0] word_cnt_q;
    logic          push;
    logic          pop;

    assign msg_ready = (cnt_q != 2'd2);
    assign enc_valid = (cnt_q != 2'd0);
    assign push      = msg_valid && msg_ready;
    assign pop       = enc_valid && enc_ready;
    assign word_cnt  = word_cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0]   <= '0;
            mem_q[1]   <= '0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            cnt_q      <= 2'd0;
            word_cnt_q <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= code;
                wr_ptr_q        <= ~wr_ptr_q;
                word_cnt_q      <= word_cnt_q + CW'(1);
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            cnt_q <= cnt_d;
        end
    end

    // Map the position-indexed head entry onto the [1:N] output.
    always_comb begin
        encoded_msg = '0;
        if (enc_valid) begin
            for (int i = 1; i <= N; i++) begin
                encoded_msg[i] = mem_q[rd_ptr_q][i];
            end
        end
    end

endmodule

// File: doc/hamm_enco_stream.md
HAMM_ENCO_STREAM -- requirements
Module: hamm_enco_stream

Interface
REQ-001 SHALL have parameter K, default 16: data bits per word.
REQ-002 SHALL have parameter P, default 5: Hamming parity bits; legal only when 2^P >= K+P+1, otherwise elaboration SHALL fail.
REQ-003 SHALL have parameter SECDED, default 0: 1 appends an overall even-parity bit.
REQ-004 SHALL have parameter CW, default 16: width of the word counter.
REQ-005 SHALL derive localparam N = K+P+SECDED as the codeword width.
REQ-006 SHALL have port clk  input  1: single clock, all state changes on its rising edge.
REQ-007 SHALL have port rst_n  input  1: asynchronous, active-low reset.
REQ-008 SHALL have port msg  input  [1:K]: data word, msg[1] is the first data bit.
REQ-009 SHALL have port msg_valid  input  1: msg is presented.
REQ-010 SHALL have port msg_ready  output  1: the block can accept a word.
REQ-011 SHALL have port inj_en  input  1: flip one codeword bit of the word accepted this cycle.
REQ-012 SHALL have port inj_pos  input  [$clog2(N+1)-1:0]: 1-based position to flip; 0 or >N means no flip.
REQ-013 SHALL have port encoded_msg  output  [1:N]: codeword at the buffer head.
REQ-014 SHALL have port enc_valid  output  1: encoded_msg is valid.
REQ-015 SHALL have port enc_ready  input  1: downstream accepts encoded_msg.
REQ-016 SHALL have port word_cnt  output  [CW-1:0]: count of words accepted.

Function
REQ-017 Codeword positions 1..K+P SHALL place parity bit p[i] at position 2^(i-1) and msg[1..K], in order, at the remaining positions ascending.
REQ-018 p[i] SHALL be the XOR of all data bits whose position has bit (i-1) set.
REQ-019 With SECDED=1, position N SHALL hold the XOR of positions 1..K+P, so the whole codeword has even parity.
REQ-020 With K=16, P=5, SECDED=0 the layout SHALL be {p1,p2,m1,p3,m2..m4,p4,m5..m11,p5,m12..m16}.
REQ-021 Injection SHALL apply after the parity computation (including the SECDED bit); parity is never recomputed over the flipped bit.
REQ-022 Encoded words SHALL enter a 2-entry FIFO; a word is accepted when msg_valid && msg_ready at a clock edge.
REQ-023 msg_ready SHALL equal (FIFO not full); when full, the FIFO SHALL not accept a word, even if a pop occurs in the same cycle.
REQ-024 enc_valid SHALL equal (FIFO not empty); encoded_msg SHALL show the oldest entry and stay stable while enc_valid && !enc_ready.
REQ-025 Latency: a word accepted at edge t SHALL appear at edge t+1 when the FIFO was empty; throughput SHALL be 1 word/cycle while enc_ready=1.
REQ-026 A push and a pop in the same cycle with 1 entry SHALL leave occupancy at 1 and preserve order.
REQ-027 When empty, encoded_msg SHALL read all zeros.
REQ-028 word_cnt SHALL increment by 1 on each accepted word and wrap from 2^CW-1 to 0.

Reset
REQ-029 rst_n low SHALL immediately clear the FIFO and word_cnt, with no clock required.
REQ-030 During and after reset: enc_valid=0, encoded_msg=0, word_cnt=0, msg_ready=1.
REQ-031 Reset asserted mid-stream SHALL discard buffered words, and none SHALL emerge after release.

Verification
REQ-032 Defaults, msg=16'h8000 (msg[1]=1), valid one cycle, enc_ready=1 -> next cycle enc_valid=1, encoded_msg=21'h1C0000, word_cnt=1.
REQ-033 Defaults, msg=16'h0000 with inj_en=1, inj_pos=21 -> encoded_msg=21'h000001; with inj_pos=0 -> 21'h000000.
REQ-034 enc_ready=0 while pushing 3 consecutive words -> msg_ready drops after 2 accepts; enc_ready=1 then drains words 1,2 in order; the third is accepted only once an entry frees.
REQ-035 SECDED=1 (N=22), msg=16'h8000 -> encoded_msg=22'h380001.
REQ-036 Assert rst_n low with 2 entries buffered -> enc_valid=0 and word_cnt=0 with no clock edge; nothing is emitted after release.
REQ-037 CW=4, accept 17 words -> word_cnt=1; random K/P legal configurations checked against a reference encoder model.
